// File: rtl/core_pkg.sv
// core_pkg: shared pipeline encodings for the 5-stage MIPS core
package core_pkg;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1
  } state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MEMREAD_BIT = 1;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use, branch/jump flush and data-memory wait control
module hazard_unit
  import core_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic             i_ex_memread,
  input  logic [4:0]       i_ex_rt,
  input  logic             i_jump,
  input  logic             i_br_taken,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  output logic             o_stall,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic             o_freeze,
  output logic             o_mem_err,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);
  state_t st, eff;
  logic [7:0] wcnt;
  logic err, mw, tmo, lu, br, jp;
  logic [CNT_W-1:0] stall_q, flush_q;
  // reset forces the decode to see RUN so outputs never reflect a stale wait
  assign eff = i_rst ? ST_RUN : st;
  assign mw  = eff == ST_MEM_WAIT;
  assign tmo = mw && !i_dmem_ready && wcnt == 8'(WAIT_MAX - 1);
  assign lu  = i_ex_memread && i_ex_rt != REG_ZERO &&
               (i_ex_rt == i_id_rs || (i_id_uses_rt && i_ex_rt == i_id_rt));
  assign o_freeze      = (!mw && i_dmem_req && !i_dmem_ready) || (mw && !i_dmem_ready && !tmo);
  assign br            = !o_freeze && i_br_taken;
  assign jp            = !o_freeze && !i_br_taken && i_jump;
  assign o_stall       = !o_freeze && !i_br_taken && !i_jump && lu;
  assign o_pc_write    = !o_freeze && !o_stall;
  assign o_if_id_write = !o_freeze && !o_stall;
  assign o_flush_if_id = br || jp;
  assign o_flush_id_ex = br;
  assign o_state       = eff;
  assign o_mem_err     = err && !i_rst;
  assign o_stall_cnt   = i_rst ? '0 : stall_q;
  assign o_flush_cnt   = i_rst ? '0 : flush_q;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      st   <= ST_RUN;
      wcnt <= '0;
      err  <= 1'b0;
    end else if (st == ST_RUN) begin
      if (i_dmem_req && !i_dmem_ready) begin
        st   <= ST_MEM_WAIT;
        wcnt <= '0;
      end
    end else if (i_dmem_ready || tmo) begin
      st  <= ST_RUN;
      err <= err || tmo;
    end else begin
      wcnt <= wcnt + 8'd1;
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(i_clk), .rst(i_rst), .clr(1'b0), .en(o_stall || o_freeze), .cnt(stall_q)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(i_clk), .rst(i_rst), .clr(1'b0), .en(o_flush_if_id || o_flush_id_ex), .cnt(flush_q)
  );
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of hazard_unit with WAIT_MAX=4, CNT_W=4
module tb_hazard_unit;
  logic clk = 0, rst = 0;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, ex_memread, jump, br_taken, dmem_req, dmem_ready;
  logic stall, pc_write, if_id_write, flush_if_id, flush_id_ex, freeze, mem_err;
  logic [1:0] state;
  logic [3:0] stall_cnt, flush_cnt;
  int tests = 0, fails = 0;

  hazard_unit #(.CNT_W(4), .WAIT_MAX(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_ex_memread(ex_memread), .i_ex_rt(ex_rt), .i_jump(jump), .i_br_taken(br_taken),
    .i_dmem_req(dmem_req), .i_dmem_ready(dmem_ready), .o_stall(stall), .o_pc_write(pc_write),
    .o_if_id_write(if_id_write), .o_flush_if_id(flush_if_id), .o_flush_id_ex(flush_id_ex),
    .o_freeze(freeze), .o_mem_err(mem_err), .o_state(state), .o_stall_cnt(stall_cnt),
    .o_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0; ex_memread = 0;
    jump = 0; br_taken = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1; step(); step(); rst = 0; #1;
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL rst_state: got %0d want 0", state); end
    tests++; if (mem_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", mem_err); end
    tests++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin fails++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    tests++; if ({pc_write, if_id_write, stall, freeze, flush_if_id, flush_id_ex} !== 6'b110000) begin fails++; $display("FAIL rst_ctl: got %b want 110000", {pc_write, if_id_write, stall, freeze, flush_if_id, flush_id_ex}); end
  endtask

  task automatic test_load_use();
    ex_memread = 1; ex_rt = 8; id_rs = 8; #1;
    tests++; if ({stall, pc_write, if_id_write} !== 3'b100) begin fails++; $display("FAIL lu_ctl: got %b want 100", {stall, pc_write, if_id_write}); end
    step(); ex_memread = 0; #1;
    tests++; if ({stall, pc_write, if_id_write} !== 3'b011) begin fails++; $display("FAIL lu_release: got %b want 011", {stall, pc_write, if_id_write}); end
    tests++; if (stall_cnt !== 4'd1) begin fails++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
    step(); idle();
  endtask

  task automatic test_no_stall();
    ex_memread = 1; ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 1; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_r0: got %b want 0", stall); end
    ex_rt = 9; id_rt = 9; id_rs = 3; id_uses_rt = 0; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_no_rt: got %b want 0", stall); end
    id_uses_rt = 1; #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_rt: got %b want 1", stall); end
    idle(); step();
    tests++; if (stall_cnt !== 4'd1) begin fails++; $display("FAIL nostall_cnt: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_branch_priority();
    br_taken = 1; jump = 1; ex_memread = 1; ex_rt = 8; id_rs = 8; #1;
    tests++; if ({flush_if_id, flush_id_ex, stall, pc_write} !== 4'b1101) begin fails++; $display("FAIL br_ctl: got %b want 1101", {flush_if_id, flush_id_ex, stall, pc_write}); end
    step(); idle(); #1;
    tests++; if (flush_cnt !== 4'd1 || stall_cnt !== 4'd1) begin fails++; $display("FAIL br_cnt: got %0d/%0d want 1/1", flush_cnt, stall_cnt); end
    jump = 1; ex_memread = 1; ex_rt = 8; id_rs = 8; #1;
    tests++; if ({flush_if_id, flush_id_ex, stall, pc_write} !== 4'b1001) begin fails++; $display("FAIL jmp_ctl: got %b want 1001", {flush_if_id, flush_id_ex, stall, pc_write}); end
    step(); idle(); #1;
    tests++; if (flush_cnt !== 4'd2) begin fails++; $display("FAIL jmp_cnt: got %0d want 2", flush_cnt); end
  endtask

  task automatic test_mem_wait();
    dmem_req = 1; br_taken = 1; #1;
    tests++; if ({freeze, pc_write, if_id_write, stall, flush_if_id, flush_id_ex} !== 6'b100000) begin fails++; $display("FAIL mw_entry: got %b want 100000", {freeze, pc_write, if_id_write, stall, flush_if_id, flush_id_ex}); end
    step(); dmem_req = 0; #1;
    tests++; if (state !== 2'd1 || freeze !== 1'b1 || flush_if_id !== 1'b0) begin fails++; $display("FAIL mw_wait1: got st=%0d frz=%b fl=%b want 1/1/0", state, freeze, flush_if_id); end
    step();
    tests++; if (freeze !== 1'b1) begin fails++; $display("FAIL mw_wait2: got %b want 1", freeze); end
    step(); dmem_ready = 1; #1;
    tests++; if ({freeze, flush_if_id, flush_id_ex, pc_write} !== 4'b0111) begin fails++; $display("FAIL mw_ready: got %b want 0111", {freeze, flush_if_id, flush_id_ex, pc_write}); end
    step(); idle(); #1;
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL mw_exit: got %0d want 0", state); end
    tests++; if (stall_cnt !== 4'd4 || flush_cnt !== 4'd3) begin fails++; $display("FAIL mw_cnt: got %0d/%0d want 4/3", stall_cnt, flush_cnt); end
    dmem_req = 1; dmem_ready = 1; #1;
    tests++; if (freeze !== 1'b0 || pc_write !== 1'b1) begin fails++; $display("FAIL mw_hit: got frz=%b pcw=%b want 0/1", freeze, pc_write); end
    step(); idle(); #1;
    tests++; if (state !== 2'd0 || stall_cnt !== 4'd4) begin fails++; $display("FAIL mw_hit_st: got st=%0d cnt=%0d want 0/4", state, stall_cnt); end
  endtask

  task automatic test_timeout();
    dmem_req = 1; step(); dmem_req = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (freeze !== 1'b1 || state !== 2'd1) begin fails++; $display("FAIL to_wait%0d: got frz=%b st=%0d want 1/1", i, freeze, state); end
      step();
    end
    tests++; if (freeze !== 1'b0 || mem_err !== 1'b0) begin fails++; $display("FAIL to_last: got frz=%b err=%b want 0/0", freeze, mem_err); end
    step();
    tests++; if (state !== 2'd0 || mem_err !== 1'b1) begin fails++; $display("FAIL to_err: got st=%0d err=%b want 0/1", state, mem_err); end
    tests++; if (stall_cnt !== 4'd8) begin fails++; $display("FAIL to_cnt: got %0d want 8", stall_cnt); end
    step(); step();
    tests++; if (mem_err !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b want 1", mem_err); end
  endtask

  task automatic test_reset_mid_wait();
    dmem_req = 1; step(); dmem_req = 0; step();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL rmw_pre: got %0d want 1", state); end
    rst = 1; step(); rst = 0; #1;
    tests++; if (state !== 2'd0 || mem_err !== 1'b0) begin fails++; $display("FAIL rmw_state: got st=%0d err=%b want 0/0", state, mem_err); end
    tests++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin fails++; $display("FAIL rmw_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    tests++; if (freeze !== 1'b0) begin fails++; $display("FAIL rmw_frz: got %b want 0", freeze); end
    dmem_req = 1; #1;
    tests++; if (freeze !== 1'b1) begin fails++; $display("FAIL rmw_req: got %b want 1", freeze); end
    dmem_ready = 1; #1;
    tests++; if (freeze !== 1'b0) begin fails++; $display("FAIL rmw_rdy: got %b want 0", freeze); end
    idle();
  endtask

  task automatic test_saturate();
    ex_memread = 1; ex_rt = 5; id_rs = 5;
    for (int i = 0; i < 20; i++) step();
    tests++; if (stall !== 1'b1 || stall_cnt !== 4'd15) begin fails++; $display("FAIL sat: got stall=%b cnt=%0d want 1/15", stall, stall_cnt); end
    idle(); step();
    tests++; if (stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_hold: got %0d want 15", stall_cnt); end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_priority();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core. Drives the ID stage's control-bubble select and ID/EX flush, and holds or flushes the PC and IF/ID register. It resolves load-use hazards, taken-branch and jump flushes, and multi-cycle data-memory waits. It exposes sticky error and stall/flush event counters for debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush event counters
- WAIT_MAX, 15, maximum data-memory wait cycles before timeout (1..255)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_id_rs  in  5  rs field of instruction in ID (instr[25:21])
- i_id_rt  in  5  rt field of instruction in ID (instr[20:16])
- i_id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
- i_ex_memread  in  1  MemRead of instruction in EX (ID/EX MEM control bit 1)
- i_ex_rt  in  5  target register of instruction in EX
- i_jump  in  1  jump decoded in ID (Flush_control from main control)
- i_br_taken  in  1  branch in MEM resolved taken (Branch & zero)
- i_dmem_req  in  1  MEM stage issues a load/store this cycle
- i_dmem_ready  in  1  data memory completes the access
- o_stall  out  1  to ID bubble select; zeroes control fields into ID/EX
- o_pc_write  out  1  PC update enable
- o_if_id_write  out  1  IF/ID load enable
- o_flush_if_id  out  1  clear IF/ID to NOP
- o_flush_id_ex  out  1  clear ID/EX (ID stage Flush input)
- o_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB (memory wait)
- o_mem_err  out  1  sticky: memory wait exceeded WAIT_MAX
- o_state  out  2  FSM state (debug)
- o_stall_cnt  out  CNT_W  cycles with o_stall or o_freeze high
- o_flush_cnt  out  CNT_W  cycles with any flush asserted

## Operation
- Hazard decode is combinational from inputs and current state. State, wait counter, error flag, and event counters are registered.
- States: RUN=0, MEM_WAIT=1.
- load_use = i_ex_memread & (i_ex_rt != 0) & ((i_ex_rt == i_id_rs) | (i_id_uses_rt & i_ex_rt == i_id_rt)).
- Priority, highest first: memory wait, taken branch, jump, load-use.
- Memory wait: active when i_dmem_req & ~i_dmem_ready in RUN, or when in MEM_WAIT & ~i_dmem_ready.
  - Drives o_freeze=1, o_pc_write=0, o_if_id_write=0, o_stall=0, and no flushes.
- Taken branch (i_br_taken, no memory wait):
  - o_flush_if_id=1, o_flush_id_ex=1, o_pc_write=1 (branch target selected outside).
  - Overrides load-use and jump in the same cycle.
- Jump (i_jump, no branch, no wait): o_flush_if_id=1, o_pc_write=1. ID/EX is not flushed.
- Load-use (alone): o_stall=1, o_pc_write=0, o_if_id_write=0. Exactly one bubble per occurrence, because the EX instruction advances.
- No hazard: o_pc_write=1, o_if_id_write=1, all other controls 0.
- Transitions:
  - RUN→MEM_WAIT on i_dmem_req & ~i_dmem_ready.
  - MEM_WAIT→RUN on i_dmem_ready.
  - MEM_WAIT→RUN on timeout.
- Wait counter:
  - Cleared on entry to MEM_WAIT; increments each MEM_WAIT cycle.
  - When it reaches WAIT_MAX while not ready: set o_mem_err (sticky until reset), go to RUN, drop o_freeze.
- Counters saturate at all-ones; they never wrap.

## Timing
- Reset values: state RUN, wait counter 0, o_mem_err 0, o_stall_cnt 0, o_flush_cnt 0.
- During reset, outputs decode as RUN with zeroed flag and counters. Reset mid-wait aborts MEM_WAIT the following cycle.
- Control outputs have zero-cycle latency: they are valid in the same cycle as the inputs.
- Counters and o_mem_err update on the clock edge that ends the qualifying cycle.
- A request with i_dmem_ready high in the same cycle causes no freeze and no state change.
- In the cycle i_dmem_ready rises during MEM_WAIT, o_freeze=0 and normal hazard priority applies.
- Freeze duration equals ready latency. It is bounded by WAIT_MAX cycles.
- Load-use against $0 never stalls.

## Structure
- Shared package core_pkg: state encoding (ST_RUN, ST_MEM_WAIT), register-zero constant, control-bit indices (MEMREAD_BIT=1).
- Natural sub-module: sat_counter (parameterised width, enable, synchronous clear), instantiated twice.

## Test plan
- Load-use: EX lw rt=8 with MemRead=1, ID rs=8 → o_stall=1, o_pc_write=0, o_if_id_write=0 for exactly 1 cycle; o_stall_cnt=1.
- Load-use on rt=0, and on rt match with i_id_uses_rt=0 → no stall.
- i_br_taken=1 together with load_use and i_jump → o_flush_if_id=1, o_flush_id_ex=1, o_stall=0; o_flush_cnt increments by 1.
- i_dmem_req=1 with ready after 3 cycles, and a concurrent i_br_taken → o_freeze=1 for 3 cycles with no flush; flush asserted in the ready cycle; o_state returns to 0.
- WAIT_MAX=4 with ready never asserted → o_mem_err=1 after 4 MEM_WAIT cycles, state RUN; o_mem_err stays 1 until i_rst.
- Synchronous i_rst asserted during MEM_WAIT → next cycle o_state=0, counters 0, o_freeze follows inputs only.
